// File: rtl/perceptron_train_ctrl_pkg.sv
// Shared types and select encodings for the perceptron training controller.
package perceptron_train_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_FETCH,
        ST_MAC1,
        ST_MAC2,
        ST_CHECK,
        ST_ALPHAT,
        ST_UPD_W1,
        ST_UPD_W2,
        ST_UPD_B,
        ST_EPOCH_END,
        ST_DONE
    } state_t;

    // Multiplier operand 1
    localparam logic [1:0] SEL1_W1     = 2'b00;
    localparam logic [1:0] SEL1_W2     = 2'b01;
    localparam logic [1:0] SEL1_T      = 2'b10;
    localparam logic [1:0] SEL1_ALPHAT = 2'b11;

    // Multiplier operand 2
    localparam logic [1:0] SEL2_ALPHA  = 2'b00;
    localparam logic [1:0] SEL2_X1     = 2'b01;
    localparam logic [1:0] SEL2_X2     = 2'b10;
    localparam logic [1:0] SEL2_ZERO   = 2'b11;

    // Adder operand 1
    localparam logic [1:0] ADD1_YIN    = 2'b00;
    localparam logic [1:0] ADD1_B      = 2'b01;
    localparam logic [1:0] ADD1_W1     = 2'b10;
    localparam logic [1:0] ADD1_W2     = 2'b11;

    // Adder operand 2
    localparam logic       ADD2_ALPHAT = 1'b0;
    localparam logic       ADD2_MULT   = 1'b1;

endpackage

// File: rtl/perceptron_train_ctrl_sample_epoch_counter.sv
// Sample address and epoch index registers with clear/increment and terminal flags.
module sample_epoch_counter #(
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned MAX_EPOCHS  = 16,
    parameter int unsigned ADDR_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_addr_i,
    input  logic              inc_addr_i,
    input  logic              clr_epoch_i,
    input  logic              inc_epoch_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        epoch_o,
    output logic              last_smp_c,
    output logic              last_epoch_c
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        epoch_q, epoch_d;

    // Clear wins over increment so an epoch restart always lands on sample 0
    always_comb begin
        addr_d  = addr_q;
        epoch_d = epoch_q;
        if (clr_addr_i)       addr_d  = '0;
        else if (inc_addr_i)  addr_d  = addr_q + ADDR_W'(1);
        if (clr_epoch_i)      epoch_d = '0;
        else if (inc_epoch_i) epoch_d = epoch_q + 8'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            epoch_q <= '0;
        end else begin
            addr_q  <= addr_d;
            epoch_q <= epoch_d;
        end
    end

    assign addr_o       = addr_q;
    assign epoch_o      = epoch_q;
    assign last_smp_c   = (addr_q == ADDR_W'(NUM_SAMPLES - 1));
    assign last_epoch_c = (epoch_q == 8'(MAX_EPOCHS - 1));

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Sequencer for the two-input perceptron training datapath: fetch, net input, conditional update.
module perceptron_train_ctrl
    import perceptron_train_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned MAX_EPOCHS  = 16,
    parameter int unsigned ADDR_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              smpValid,
    input  logic              compare,
    input  logic              flag,
    output logic              smpReq,
    output logic [ADDR_W-1:0] smpAddr,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [7:0]        epoch,
    output logic              InitYin,
    output logic              InitW1,
    output logic              InitW2,
    output logic              InitB,
    output logic              InitFlag,
    output logic              InitAlpha,
    output logic              LdX1,
    output logic              LdX2,
    output logic              LdT,
    output logic              LdYin,
    output logic              LdFlag,
    output logic              LdAlphaT,
    output logic              LdW1,
    output logic              LdW2,
    output logic              LdB,
    output logic              Select2,
    output logic [1:0]        Select1,
    output logic [1:0]        Sel1,
    output logic [1:0]        Sel2
);

    state_t state_q, state_d;
    logic   converged_q, converged_d;
    logic   clr_addr, inc_addr, clr_epoch, inc_epoch;
    logic   last_smp, last_epoch;

    sample_epoch_counter #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .MAX_EPOCHS  (MAX_EPOCHS),
        .ADDR_W      (ADDR_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_addr_i   (clr_addr),
        .inc_addr_i   (inc_addr),
        .clr_epoch_i  (clr_epoch),
        .inc_epoch_i  (inc_epoch),
        .addr_o       (smpAddr),
        .epoch_o      (epoch),
        .last_smp_c   (last_smp),
        .last_epoch_c (last_epoch)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            converged_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            converged_q <= converged_d;
        end
    end

    // Next state and Moore controls; only the FETCH loads depend on smpValid
    always_comb begin
        state_d     = state_q;
        converged_d = converged_q;
        clr_addr    = 1'b0;
        inc_addr    = 1'b0;
        clr_epoch   = 1'b0;
        inc_epoch   = 1'b0;
        smpReq      = 1'b0;
        InitYin     = 1'b0;
        InitW1      = 1'b0;
        InitW2      = 1'b0;
        InitB       = 1'b0;
        InitFlag    = 1'b0;
        InitAlpha   = 1'b0;
        LdX1        = 1'b0;
        LdX2        = 1'b0;
        LdT         = 1'b0;
        LdYin       = 1'b0;
        LdFlag      = 1'b0;
        LdAlphaT    = 1'b0;
        LdW1        = 1'b0;
        LdW2        = 1'b0;
        LdB         = 1'b0;
        Select2     = 1'b0;
        Select1     = 2'b00;
        Sel1        = 2'b00;
        Sel2        = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    converged_d = 1'b0;
                end
            end
            ST_INIT: begin
                InitW1    = 1'b1;
                InitW2    = 1'b1;
                InitB     = 1'b1;
                InitYin   = 1'b1;
                InitFlag  = 1'b1;
                InitAlpha = 1'b1;
                clr_addr  = 1'b1;
                clr_epoch = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_FETCH: begin
                smpReq = 1'b1;
                if (smpValid) begin
                    LdX1    = 1'b1;
                    LdX2    = 1'b1;
                    LdT     = 1'b1;
                    state_d = ST_MAC1;
                end
            end
            ST_MAC1: begin
                Sel1    = SEL1_W1;
                Sel2    = SEL2_X1;
                Select1 = ADD1_B;
                Select2 = ADD2_MULT;
                LdYin   = 1'b1;
                state_d = ST_MAC2;
            end
            ST_MAC2: begin
                Sel1    = SEL1_W2;
                Sel2    = SEL2_X2;
                Select1 = ADD1_YIN;
                Select2 = ADD2_MULT;
                LdYin   = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (compare) begin
                    state_d = ST_ALPHAT;
                end else if (last_smp) begin
                    state_d = ST_EPOCH_END;
                end else begin
                    inc_addr = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_ALPHAT: begin
                Sel1     = SEL1_T;
                Sel2     = SEL2_ALPHA;
                LdAlphaT = 1'b1;
                state_d  = ST_UPD_W1;
            end
            ST_UPD_W1: begin
                Sel1    = SEL1_ALPHAT;
                Sel2    = SEL2_X1;
                Select1 = ADD1_W1;
                Select2 = ADD2_MULT;
                LdW1    = 1'b1;
                state_d = ST_UPD_W2;
            end
            ST_UPD_W2: begin
                Sel1    = SEL1_ALPHAT;
                Sel2    = SEL2_X2;
                Select1 = ADD1_W2;
                Select2 = ADD2_MULT;
                LdW2    = 1'b1;
                state_d = ST_UPD_B;
            end
            ST_UPD_B: begin
                Select1 = ADD1_B;
                Select2 = ADD2_ALPHAT;
                LdB     = 1'b1;
                LdFlag  = 1'b1;
                if (last_smp) begin
                    state_d = ST_EPOCH_END;
                end else begin
                    inc_addr = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_EPOCH_END: begin
                if (!flag) begin
                    converged_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (last_epoch) begin
                    converged_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    InitFlag  = 1'b1;
                    inc_epoch = 1'b1;
                    clr_addr  = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    converged_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign converged = converged_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Scoreboarded bench for perceptron_train_ctrl with reactive sample memory and flag model.
module tb_perceptron_train_ctrl;
    import perceptron_train_ctrl_pkg::*;

    localparam int unsigned NS  = 4;
    localparam int unsigned ME  = 3;
    localparam int unsigned AW  = 2;

    logic          clk = 1'b0;
    logic          rst, start, smpValid, compare, flag;
    logic          smpReq, busy, done, converged;
    logic [AW-1:0] smpAddr;
    logic [7:0]    epoch;
    logic          InitYin, InitW1, InitW2, InitB, InitFlag, InitAlpha;
    logic          LdX1, LdX2, LdT, LdYin, LdFlag, LdAlphaT, LdW1, LdW2, LdB;
    logic          Select2;
    logic [1:0]    Select1, Sel1, Sel2;

    perceptron_train_ctrl #(.NUM_SAMPLES(NS), .MAX_EPOCHS(ME)) dut (
        .clk(clk), .rst(rst), .start(start), .smpValid(smpValid),
        .compare(compare), .flag(flag), .smpReq(smpReq), .smpAddr(smpAddr),
        .busy(busy), .done(done), .converged(converged), .epoch(epoch),
        .InitYin(InitYin), .InitW1(InitW1), .InitW2(InitW2), .InitB(InitB),
        .InitFlag(InitFlag), .InitAlpha(InitAlpha), .LdX1(LdX1), .LdX2(LdX2),
        .LdT(LdT), .LdYin(LdYin), .LdFlag(LdFlag), .LdAlphaT(LdAlphaT),
        .LdW1(LdW1), .LdW2(LdW2), .LdB(LdB), .Select2(Select2),
        .Select1(Select1), .Sel1(Sel1), .Sel2(Sel2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycles;
        int conv;
        int epoch;
        int upd;
        int iflag;
    } result_t;

    int      exp_addr_q[$];
    result_t exp_res_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    int cmode    = 0;   // 0: never misclassify, 1: always, 2: only epoch 0 sample 2
    int dly_mode = 0;   // 1: hold off smpValid 5 cycles for sample 1
    bit mon_en   = 1'b0;
    int req_cycles = 0;
    int req_len  = 0;
    int req_addr = 0;
    bit mac_phase = 1'b0;
    bit flag_nx  = 1'b0;
    int cnt_w1 = 0, cnt_w2 = 0, cnt_b = 0, cnt_iflag = 0, cnt_initw = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] ctrl_vec();
        return {smpReq, busy, done, converged, InitYin, InitW1, InitW2, InitB,
                InitFlag, InitAlpha, LdX1, LdX2, LdT, LdYin, LdFlag, LdAlphaT,
                LdW1, LdW2, LdB, Select2, Select1, Sel1, Sel2};
    endfunction

    function automatic logic [6:0] sel_vec();
        return {Sel1, Sel2, Select1, Select2};
    endfunction

    // Sample memory, misclassification source and datapath flag register
    always @(posedge clk) begin
        #1;
        if (smpReq) req_cycles++;
        else        req_cycles = 0;
        smpValid = smpReq && (req_cycles > ((dly_mode != 0 && smpAddr == 2'd1) ? 5 : 0));
        case (cmode)
            1:       compare = 1'b1;
            2:       compare = (epoch == 8'd0) && (smpAddr == 2'd2);
            default: compare = 1'b0;
        endcase
        flag = flag_nx;
    end

    // Protocol monitor and scoreboard consumer
    always @(negedge clk) begin
        if (InitFlag)    flag_nx = 1'b0;
        else if (LdFlag) flag_nx = 1'b1;
        if (mon_en) begin
            check_eq("ldx_mealy", {LdX1, LdX2, LdT}, (smpReq && smpValid) ? 3'b111 : 3'b000);
            if (smpReq) begin
                if (req_len == 0) req_addr = int'(smpAddr);
                req_len++;
                check_eq("req_addr_stable", smpAddr, req_addr);
                check_eq("fetch_sel", sel_vec(), 7'd0);
                if (smpValid) begin
                    check_eq("smp_addr", smpAddr, (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF);
                    check_eq("req_len", req_len, (dly_mode != 0 && smpAddr == 2'd1) ? 6 : 1);
                end
            end else begin
                req_len = 0;
            end
            if (LdYin) begin
                check_eq(mac_phase ? "mac2_sel" : "mac1_sel", sel_vec(),
                         mac_phase ? {SEL1_W2, SEL2_X2, ADD1_YIN, ADD2_MULT}
                                   : {SEL1_W1, SEL2_X1, ADD1_B, ADD2_MULT});
                mac_phase = ~mac_phase;
            end
            if (LdAlphaT) check_eq("alphat_sel", sel_vec(), {SEL1_T, SEL2_ALPHA, ADD1_YIN, 1'b0});
            if (LdW1) begin
                check_eq("upd_w1_sel", sel_vec(), {SEL1_ALPHAT, SEL2_X1, ADD1_W1, ADD2_MULT});
                cnt_w1++;
            end
            if (LdW2) begin
                check_eq("upd_w2_sel", sel_vec(), {SEL1_ALPHAT, SEL2_X2, ADD1_W2, ADD2_MULT});
                cnt_w2++;
            end
            if (LdB) begin
                check_eq("upd_b_sel", {sel_vec(), LdFlag}, {SEL1_W1, SEL2_ALPHA, ADD1_B, ADD2_ALPHAT, 1'b1});
                cnt_b++;
            end
            if (InitFlag) cnt_iflag++;
            if (InitW1)   cnt_initw++;
        end
    end

    task automatic do_run(input int mode, input int dly, input int n_epochs, input int exp_cycles,
                          input int exp_conv, input int exp_epoch, input int exp_upd,
                          input int exp_iflag, input bit mac2_start);
        result_t r;
        int cyc;
        cmode = mode;
        dly_mode = dly;
        for (int e = 0; e < n_epochs; e++)
            for (int a = 0; a < int'(NS); a++) exp_addr_q.push_back(a);
        r.cycles = exp_cycles; r.conv = exp_conv; r.epoch = exp_epoch;
        r.upd = exp_upd; r.iflag = exp_iflag;
        exp_res_q.push_back(r);
        cnt_w1 = 0; cnt_w2 = 0; cnt_b = 0; cnt_iflag = 0; cnt_initw = 0;
        mac_phase = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        check_eq("init_state", {InitW1, InitFlag, InitAlpha, busy, done, converged}, 6'b111100);
        while (!done && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mac2_start && cyc == 4) begin
                check_eq("mac2_start_busy", {busy, Sel2}, {1'b1, SEL2_X2});
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        r = exp_res_q.pop_front();
        check_eq("done", done, 1);
        check_eq("cycles", cyc, r.cycles);
        check_eq("converged", converged, r.conv);
        check_eq("epoch", epoch, r.epoch);
        check_eq("busy_done", busy, 0);
        check_eq("upd_b_count", cnt_b, r.upd);
        check_eq("upd_w_count", {cnt_w1[15:0], cnt_w2[15:0]}, {r.upd[15:0], r.upd[15:0]});
        check_eq("init_flag_count", cnt_iflag, r.iflag);
        check_eq("init_w_count", cnt_initw, 1);
        check_eq("addr_q_left", exp_addr_q.size(), 0);
        exp_addr_q.delete();
        mon_en = 1'b0;
    endtask

    initial begin
        bit hit;
        rst = 1'b0; start = 1'b0; smpValid = 1'b0; compare = 1'b0; flag = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", ctrl_vec(), 26'd0);
        check_eq("reset_cnt", {smpAddr, epoch}, 10'd0);
        rst = 1'b1;
        @(negedge clk);

        // Clean epoch with an ignored start pulse during MAC2
        do_run(0, 0, 1, 19, 1, 0, 0, 1, 1'b1);
        // One update in epoch 0, restarted from DONE, converges after epoch 1
        do_run(2, 0, 2, 40, 1, 1, 1, 2, 1'b0);
        // Always misclassified: epoch limit reached
        do_run(1, 0, 3, 101, 0, 2, 12, 3, 1'b0);
        // Slow sample memory on sample 1
        do_run(0, 1, 1, 24, 1, 0, 0, 1, 1'b0);

        // Abort from UPD_W2 with reset
        cmode = 1; dly_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (LdW2) hit = 1'b1;
        end
        check_eq("reach_upd_w2", hit, 1);
        rst = 1'b0;
        #1;
        check_eq("abort_ctrl_async", ctrl_vec(), 26'd0);
        @(negedge clk);
        check_eq("abort_ctrl", ctrl_vec(), 26'd0);
        check_eq("abort_cnt", {smpAddr, epoch}, 10'd0);
        rst = 1'b1;
        @(negedge clk);
        do_run(0, 0, 1, 19, 1, 0, 0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
